// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int INSTR_BYTES = 4;

    // One fetched instruction together with the PC it was read from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // IDLE: nothing outstanding. WAIT: one request outstanding, its response
    // is kept. KILL: one request outstanding, its response is thrown away.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        KILL = 2'd2
    } fetch_state_t;

    // Sequential PC; wraps modulo 2^32.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + 32'(INSTR_BYTES);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries feeding decode.
// head_o is the oldest entry; it is meaningful only while count_o != 0.
// clear_i empties the FIFO and takes priority over push_i/pop_i.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic                         clear_i,
    input  fetch_entry_t                 data_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output fetch_entry_t                 head_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage, pointers and occupancy; storage resets to zero so the head
    // reads as zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clear_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop_i) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues single-word reads to instruction memory
// (at most one outstanding) and queues {pc, instr} for decode.
//
// Handshake: decode takes the head entry in any cycle where valid_o and
// ready_i are both high and no redirect is present; valid_o never depends on
// ready_i. A memory request is presented for exactly one cycle (imem_rmask
// 4'b1111 with imem_addr); imem_resp pulses once per request with imem_rdata.
//
// Optional feature macro FETCH_PERF_EN adds perf_fetch_o (pops) and
// perf_stall_o (cycles waiting on memory without a response).
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h1eceb000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_i,
    input  logic [31:0] target_i,
    input  logic        ready_i,
    output logic [31:0] imem_addr,
    output logic [3:0]  imem_rmask,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic [1:0]  dbg_state_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_o,
    output logic [31:0] perf_stall_o
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    typedef logic [CW-1:0] cnt_t;

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  req_pc_q, req_pc_d;

    cnt_t         fifo_count;
    cnt_t         count_next;
    fetch_entry_t fifo_head;
    fetch_entry_t push_entry;
    logic         fifo_valid;
    logic         push;
    logic         pop;
    logic         issue_slot;
    logic         issue;

    assign push_entry = '{pc: req_pc_q, instr: imem_rdata};

    // Push/pop/issue decisions. Issue looks at the occupancy after this
    // cycle's push/pop so an issued request always has a slot to land in.
    always_comb begin
        fifo_valid = (fifo_count != '0);
        pop        = fifo_valid && ready_i && !redirect_i;
        push       = (state_q == WAIT) && imem_resp && !redirect_i;
        count_next = fifo_count;
        if (push && !pop) begin
            count_next = fifo_count + 1'b1;
        end else if (pop && !push) begin
            count_next = fifo_count - 1'b1;
        end
        issue_slot = (state_q == IDLE) || ((state_q == WAIT) && imem_resp);
        issue      = rst && issue_slot && !redirect_i && (count_next < cnt_t'(DEPTH));
    end

    // Next state for the request FSM, the PC and the in-flight request PC.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        case (state_q)
            IDLE: begin
                if (issue) state_d = WAIT;
            end
            WAIT: begin
                if (redirect_i) begin
                    // A response in the redirect cycle retires the request.
                    state_d = imem_resp ? IDLE : KILL;
                end else if (imem_resp) begin
                    state_d = issue ? WAIT : IDLE;
                end
            end
            KILL: begin
                if (imem_resp) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (redirect_i) begin
            pc_d = target_i;
        end else if (issue) begin
            pc_d     = next_pc(pc_q);
            req_pc_d = pc_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (redirect_i),
        .data_i  (push_entry),
        .count_o (fifo_count),
        .head_o  (fifo_head)
    );

    assign imem_addr   = pc_q;
    assign imem_rmask  = issue ? 4'b1111 : 4'b0000;
    assign valid_o     = fifo_valid;
    assign pc_o        = fifo_head.pc;
    assign instr_o     = fifo_head.instr;
    assign dbg_state_o = state_q;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_stall_q;

    // Wrapping event counters: decode pops, and memory wait cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (pop) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
            if (((state_q == WAIT) || (state_q == KILL)) && !imem_resp) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fetch_o = perf_fetch_q;
    assign perf_stall_o = perf_stall_q;
`endif

endmodule
